alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Purpose: three-state (IDLE/EXEC/RESP) sequencer that decodes an op class, drives an external ALU and holds its result; ALU_ILLEGAL_TRAP_EN enables illegal-op trapping.
// Latency: result valid in the second cycle after the accept cycle; one op per three cycles at best.
// Backpressure: in_ready only in IDLE; RESP holds result/flags until out_valid && out_ready.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [31:0] alu_a1,
    output logic [31:0] alu_a2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        branch_taken,
    output logic        illegal
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       is_branch;
    } dec_t;

    logic [1:0]  state;
    dec_t        dec;
    logic        op_branch;
    logic [31:0] exec_result;
    logic        exec_taken;

`ifdef ALU_ILLEGAL_TRAP_EN
    logic        dec_illegal;
    logic        op_illegal;
    logic        illegal_r;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);

    // Undecodable ops fall back to add so the ALU still sees a defined function.
    always_comb begin
        dec.ctrl      = CTRL_ADD;
        dec.is_branch = 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
        dec_illegal   = 1'b0;
`endif
        case (alu_op)
            2'b00: dec.ctrl = CTRL_ADD;
            2'b01: begin
                dec.ctrl      = CTRL_SUB;
                dec.is_branch = 1'b1;
            end
            2'b10: begin
                case (funct3)
                    3'b000:  dec.ctrl = funct7_5 ? CTRL_SUB : CTRL_ADD;
                    3'b111:  dec.ctrl = CTRL_AND;
                    3'b110:  dec.ctrl = CTRL_OR;
                    default: begin
                        dec.ctrl = CTRL_ADD;
`ifdef ALU_ILLEGAL_TRAP_EN
                        dec_illegal = 1'b1;
`endif
                    end
                endcase
            end
            default: begin
                dec.ctrl = CTRL_ADD;
`ifdef ALU_ILLEGAL_TRAP_EN
                dec_illegal = 1'b1;
`endif
            end
        endcase
    end

`ifdef ALU_ILLEGAL_TRAP_EN
    assign exec_result = op_illegal ? 32'd0 : alu_out;
    assign exec_taken  = op_branch && alu_zero && !op_illegal;
`else
    assign exec_result = alu_out;
    assign exec_taken  = op_branch && alu_zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            alu_a1       <= 32'd0;
            alu_a2       <= 32'd0;
            alu_ctrl     <= CTRL_AND;
            op_branch    <= 1'b0;
            result       <= 32'd0;
            branch_taken <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a1    <= rs1_val;
                        alu_a2    <= rs2_val;
                        alu_ctrl  <= dec.ctrl;
                        op_branch <= dec.is_branch;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    result       <= exec_result;
                    branch_taken <= exec_taken;
                    state        <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_illegal <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                op_illegal <= dec_illegal;
            end
            if (state == EXEC) begin
                illegal_r <= op_illegal;
            end
        end
    end

    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed ops push expected responses, a monitor pops on each output handshake.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_a1;
    logic [31:0] alu_a2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        branch_taken;
    logic        illegal;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .alu_a1       (alu_a1),
        .alu_a2       (alu_a2),
        .alu_ctrl     (alu_ctrl),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    // External combinational ALU the sequencer drives.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_out = alu_a1 & alu_a2;
            4'b0001: alu_out = alu_a1 | alu_a2;
            4'b0110: alu_out = alu_a1 - alu_a2;
            default: alu_out = alu_a1 + alu_a2;
        endcase
    end
    assign alu_zero = (alu_out == 32'd0);

    typedef struct packed {
        logic [31:0] res;
        logic        bt;
        logic        ill;
        logic [3:0]  ctrl;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got result 0x%08h expected no response", result);
            end else begin
                mon_e = exp_q.pop_front();
                check32("result", result, mon_e.res);
                check32("branch_taken", 32'(branch_taken), 32'(mon_e.bt));
                check32("illegal", 32'(illegal), 32'(mon_e.ill));
                check32("alu_ctrl", 32'(alu_ctrl), 32'(mon_e.ctrl));
            end
        end
    end

    // Presents one op and returns one cycle after the accepting edge (DUT in EXEC).
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input bit push);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check32("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        alu_op   = op;
        funct3   = f3;
        funct7_5 = f7;
        rs1_val  = a;
        rs2_val  = b;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b, input exp_t e);
        issue(op, f3, f7, a, b, e, 1'b1);
        check32("exec_no_valid", 32'(out_valid), 32'd0);
        check32("exec_not_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check32("resp_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
    endtask

    exp_t ill_e;
    exp_t op11_e;

    initial begin
        in_valid  = 1'b0;
        alu_op    = 2'b00;
        funct3    = 3'b000;
        funct7_5  = 1'b0;
        rs1_val   = 32'd0;
        rs2_val   = 32'd0;
        out_ready = 1'b1;

        #12;
        check32("rst_out_valid", 32'(out_valid), 32'd0);
        check32("rst_in_ready", 32'(in_ready), 32'd1);
        check32("rst_result", result, 32'd0);
        check32("rst_branch", 32'(branch_taken), 32'd0);
        check32("rst_illegal", 32'(illegal), 32'd0);
        check32("rst_a1", alu_a1, 32'd0);
        check32("rst_a2", alu_a2, 32'd0);
        check32("rst_ctrl", 32'(alu_ctrl), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check32("post_rst_ready", 32'(in_ready), 32'd1);

`ifdef ALU_ILLEGAL_TRAP_EN
        ill_e  = '{res: 32'd0, bt: 1'b0, ill: 1'b1, ctrl: 4'b0010};
        op11_e = '{res: 32'd0, bt: 1'b0, ill: 1'b1, ctrl: 4'b0010};
`else
        ill_e  = '{res: 32'd7, bt: 1'b0, ill: 1'b0, ctrl: 4'b0010};
        op11_e = '{res: 32'd3, bt: 1'b0, ill: 1'b0, ctrl: 4'b0010};
`endif

        run_op(2'b10, 3'b000, 1'b0, 32'd5, 32'd7, '{res: 32'd12, bt: 1'b0, ill: 1'b0, ctrl: 4'b0010});
        run_op(2'b01, 3'b000, 1'b0, 32'h1234, 32'h1234, '{res: 32'd0, bt: 1'b1, ill: 1'b0, ctrl: 4'b0110});
        run_op(2'b01, 3'b000, 1'b0, 32'h1234, 32'h1235, '{res: 32'hFFFF_FFFF, bt: 1'b0, ill: 1'b0, ctrl: 4'b0110});
        run_op(2'b10, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, '{res: 32'h00F0_00F0, bt: 1'b0, ill: 1'b0, ctrl: 4'b0000});
        run_op(2'b10, 3'b110, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, '{res: 32'hFFF0_FFF0, bt: 1'b0, ill: 1'b0, ctrl: 4'b0001});
        run_op(2'b10, 3'b000, 1'b1, 32'd10, 32'd3, '{res: 32'd7, bt: 1'b0, ill: 1'b0, ctrl: 4'b0110});
        run_op(2'b10, 3'b000, 1'b1, 32'd9, 32'd9, '{res: 32'd0, bt: 1'b0, ill: 1'b0, ctrl: 4'b0110});
        run_op(2'b00, 3'b010, 1'b1, 32'h100, 32'h20, '{res: 32'h120, bt: 1'b0, ill: 1'b0, ctrl: 4'b0010});
        run_op(2'b10, 3'b001, 1'b0, 32'd3, 32'd4, ill_e);
        run_op(2'b11, 3'b000, 1'b0, 32'd1, 32'd2, op11_e);

        // Downstream stall: response must hold and new offers must be ignored.
        out_ready = 1'b0;
        issue(2'b10, 3'b000, 1'b0, 32'h11, 32'h22, '{res: 32'h33, bt: 1'b0, ill: 1'b0, ctrl: 4'b0010}, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            alu_op   = 2'b01;
            rs1_val  = 32'hDEAD_0000 + 32'(i);
            rs2_val  = 32'h0000_BEEF;
            check32("stall_valid", 32'(out_valid), 32'd1);
            check32("stall_result", result, 32'h33);
            check32("stall_not_ready", 32'(in_ready), 32'd0);
            check32("stall_a1_hold", alu_a1, 32'h11);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check32("stall_release_ready", 32'(in_ready), 32'd1);
        check32("stall_no_capture", alu_a1, 32'h11);
        run_op(2'b10, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, '{res: 32'h0F00_0F00, bt: 1'b0, ill: 1'b0, ctrl: 4'b0000});

        // Reset in EXEC: in-flight op is dropped, outputs clear at once.
        issue(2'b10, 3'b000, 1'b0, 32'h50, 32'h60, '{res: 32'hB0, bt: 1'b0, ill: 1'b0, ctrl: 4'b0010}, 1'b0);
        rst_n = 1'b0;
        #1;
        check32("mid_rst_valid", 32'(out_valid), 32'd0);
        check32("mid_rst_ready", 32'(in_ready), 32'd1);
        check32("mid_rst_result", result, 32'd0);
        check32("mid_rst_a1", alu_a1, 32'd0);
        check32("mid_rst_a2", alu_a2, 32'd0);
        check32("mid_rst_ctrl", 32'(alu_ctrl), 32'd0);
        check32("mid_rst_branch", 32'(branch_taken), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check32("rel_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check32("rel_no_output", 32'(out_valid), 32'd0);
        end
        run_op(2'b00, 3'b000, 1'b0, 32'd1, 32'd1, '{res: 32'd2, bt: 1'b0, ill: 1'b0, ctrl: 4'b0010});

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check32("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
